// File: rtl/demux4_reg.sv
// demux4_reg: registered 1-to-4 demultiplexer with per-channel backpressure.
//
// One valid/ready input stream carries a word plus a 2-bit destination
// select. Each of the four output channels owns a one-entry register with
// an EMPTY/FULL state. A channel that is FULL and being drained on the same
// edge can accept a new word, so a free-flowing consumer sees 1 word/cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_data [WIDTH]     input word
//   in_sel  [2]         destination channel 0..3
//   out_valid[4]        channel k holds a word
//   out_ready[4]        consumer k takes its word
//   out_data0..3        channel data registers
//   cnt0..3 [8]         per-channel accepted-word counters
//
// Optional feature: define DEMUX4_CNT_EN to build the saturating counters;
// without it cnt0..cnt3 are tied to zero.
module demux4_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } chan_state_t;

  chan_state_t      r_state     [4];
  chan_state_t      w_state_nxt [4];
  logic [WIDTH-1:0] r_data      [4];
  logic             w_in_xfer;
  logic [3:0]       w_load;
  logic [3:0]       w_drain;

  // Readiness depends only on the selected channel; in_valid is not involved.
  always_comb begin
    in_ready  = !out_valid[in_sel] || out_ready[in_sel];
    w_in_xfer = in_valid && in_ready;
  end

  always_comb begin
    out_valid = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      out_valid[k] = (r_state[k] == ST_FULL);
    end
  end

  // Per-channel next state. A simultaneous load and drain keeps the channel
  // FULL with the new word.
  always_comb begin
    w_load  = '0;
    w_drain = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_state_nxt[k] = r_state[k];
      w_load[k]      = w_in_xfer && (in_sel == 2'(k));
      w_drain[k]     = out_valid[k] && out_ready[k];
      case (r_state[k])
        ST_EMPTY: if (w_load[k]) w_state_nxt[k] = ST_FULL;
        ST_FULL:  if (w_drain[k] && !w_load[k]) w_state_nxt[k] = ST_EMPTY;
        default:  w_state_nxt[k] = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 4; k++) begin
        r_state[k] <= ST_EMPTY;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        r_state[k] <= w_state_nxt[k];
      end
    end
  end

  // Data registers change only when their channel accepts a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 4; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (w_load[k]) r_data[k] <= in_data;
      end
    end
  end

  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];

`ifdef DEMUX4_CNT_EN
  logic [7:0] r_cnt [4];

  // Saturating at 8'hFF; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 4; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (w_load[k] && (r_cnt[k] != 8'hFF)) r_cnt[k] <= r_cnt[k] + 8'd1;
      end
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
  assign cnt2 = '0;
  assign cnt3 = '0;
`endif

endmodule

// File: tb/tb_demux4_reg.sv
// Testbench for demux4_reg: directed scenarios plus randomized traffic,
// checked every cycle against a per-channel queue model.
module tb_demux4_reg;

  localparam int unsigned W = 8;

`ifdef DEMUX4_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [7:0]   cnt0, cnt1, cnt2, cnt3;

  logic [W-1:0] dout [4];
  logic [7:0]   dcnt [4];
  assign dout[0] = out_data0;
  assign dout[1] = out_data1;
  assign dout[2] = out_data2;
  assign dout[3] = out_data3;
  assign dcnt[0] = cnt0;
  assign dcnt[1] = cnt1;
  assign dcnt[2] = cnt2;
  assign dcnt[3] = cnt3;

  demux4_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a queue of words waiting for its consumer.
  logic [W-1:0] q [4][$];
  int unsigned  m_cnt [4];
  bit           m_xfer;
  bit           m_stall;
  logic [1:0]   s_sel;
  logic [W-1:0] s_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        m_cnt[k] = 0;
      end
      m_xfer  = 1'b0;
      m_stall = 1'b0;
    end else begin
      bit ready;
      if (m_stall) chk("src_hold", {22'd0, in_sel, in_data}, {22'd0, s_sel, s_data});
      ready   = (q[in_sel].size() == 0) || out_ready[in_sel];
      m_xfer  = in_valid && ready;
      m_stall = in_valid && !ready;
      s_sel   = in_sel;
      s_data  = in_data;
      for (int k = 0; k < 4; k++) begin
        if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
      end
      if (m_xfer) begin
        q[in_sel].push_back(in_data);
        if (CNT_EN && m_cnt[in_sel] < 255) m_cnt[in_sel]++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] exp_valid;
    bit         exp_ready;
    exp_valid = '0;
    for (int k = 0; k < 4; k++) begin
      if (q[k].size() > 1) chk("model_depth", q[k].size(), 1);
      exp_valid[k] = (q[k].size() != 0);
    end
    exp_ready = (q[in_sel].size() == 0) || out_ready[in_sel];
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, exp_valid);
    for (int k = 0; k < 4; k++) begin
      if (exp_valid[k]) chk("out_data", dout[k], q[k][0]);
      else if (!rst_n) chk("rst_data", dout[k], 0);
      chk("cnt", dcnt[k], m_cnt[k]);
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [3:0] r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'b0000;

    // Reset values.
    #12;
    chk("rst_out_valid", out_valid, 4'b0000);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_data0", out_data0, 0);
    chk("rst_data3", out_data3, 0);
    chk("rst_cnt0", cnt0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // One word per channel, all consumers ready.
    drive(1'b1, 2'd0, 8'h11, 4'b1111);
    @(negedge clk);
    chk("t1_ready0", in_ready, 1'b1);
    drive(1'b1, 2'd1, 8'h22, 4'b1111);
    @(negedge clk);
    chk("t1_valid0", out_valid, 4'b0001);
    chk("t1_data0", out_data0, 8'h11);
    chk("t1_ready1", in_ready, 1'b1);
    drive(1'b1, 2'd2, 8'h33, 4'b1111);
    @(negedge clk);
    chk("t1_valid1", out_valid, 4'b0010);
    chk("t1_data1", out_data1, 8'h22);
    drive(1'b1, 2'd3, 8'h44, 4'b1111);
    @(negedge clk);
    chk("t1_valid2", out_valid, 4'b0100);
    chk("t1_data2", out_data2, 8'h33);
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    @(negedge clk);
    chk("t1_valid3", out_valid, 4'b1000);
    chk("t1_data3", out_data3, 8'h44);

    // Channel 2 stalls, then drains with a swap.
    drive(1'b1, 2'd2, 8'hA5, 4'b1011);
    drive(1'b1, 2'd2, 8'h5A, 4'b1011);
    @(negedge clk);
    chk("t2_stall_ready", in_ready, 1'b0);
    chk("t2_hold_data", out_data2, 8'hA5);
    drive(1'b1, 2'd2, 8'h5A, 4'b1011);
    @(negedge clk);
    chk("t2_stall_ready2", in_ready, 1'b0);
    chk("t2_hold_data2", out_data2, 8'hA5);
    drive(1'b1, 2'd2, 8'h5A, 4'b1111);
    @(negedge clk);
    chk("t2_swap_ready", in_ready, 1'b1);
    chk("t2_swap_old", out_data2, 8'hA5);
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    @(negedge clk);
    chk("t2_new_valid", out_valid[2], 1'b1);
    chk("t2_new_data", out_data2, 8'h5A);
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    @(negedge clk);
    chk("t2_drained", out_valid, 4'b0000);

    // Stalled channel 1 does not block channel 3.
    drive(1'b1, 2'd1, 8'h66, 4'b0000);
    drive(1'b1, 2'd3, 8'h77, 4'b0000);
    @(negedge clk);
    chk("t3_ready", in_ready, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("t3_valid", out_valid, 4'b1010);
    chk("t3_data1", out_data1, 8'h66);
    chk("t3_data3", out_data3, 8'h77);

    // Fill all channels, then reset asynchronously between edges.
    drive(1'b1, 2'd0, 8'h10, 4'b0000);
    drive(1'b1, 2'd2, 8'h20, 4'b0000);
    drive(1'b0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    chk("t4_all_full", out_valid, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_valid", out_valid, 4'b0000);
    chk("t4_data0", out_data0, 0);
    chk("t4_data1", out_data1, 0);
    chk("t4_data2", out_data2, 0);
    chk("t4_data3", out_data3, 0);
    chk("t4_cnt", {cnt0, cnt1, cnt2, cnt3}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 300 words to channel 0: counter saturates.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd0, W'(i), 4'b1111);
    end
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    @(negedge clk);
    chk("t5_cnt0", cnt0, CNT_EN ? 8'hFF : 8'h00);
    chk("t5_cnt1", cnt1, 8'h00);
    chk("t5_cnt2", cnt2, 8'h00);
    chk("t5_cnt3", cnt3, 8'h00);

    // Randomized traffic; source holds word and select while stalled.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!(in_valid && m_stall)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = W'($urandom);
      end
      out_ready = 4'($urandom);
    end
    drive(1'b0, 2'd0, 8'h00, 4'b1111);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
